// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event arbiter: edge modes, scheduler states,
// event record and mode decode helpers.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  // Wide enough for the largest legal channel count (16).
  localparam int EVT_CH_W = 4;

  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                rise;
  } edge_evt_t;

  function automatic logic rise_enabled(input edge_mode_t m);
    return (m == RISE) || (m == BOTH);
  endfunction

  function automatic logic fall_enabled(input edge_mode_t m);
    return (m == FALL) || (m == BOTH);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: previous-sample register, mode-masked edge detection,
// a single pending-edge slot and a sticky overflow flag.
module edge_chan
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  edge_mode_t mode,
  input  logic       drain,
  input  logic       ovf_clr,
  output logic       pend_valid,
  output logic       pend_rise,
  output logic       overflow
);

  logic prev_r;
  logic valid_r;
  logic rise_r;
  logic ovf_r;

  logic rise_s;
  logic fall_s;
  logic edge_s;
  logic load_s;
  logic drop_s;

  // Edge qualification and slot load/drop decisions.
  always_comb begin
    rise_s = a & ~prev_r & rise_enabled(mode);
    fall_s = ~a & prev_r & fall_enabled(mode);
    edge_s = rise_s | fall_s;
    load_s = edge_s & (~valid_r | drain);
    drop_s = edge_s & valid_r & ~drain;
  end

  // Sample history, pending slot and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r  <= 1'b0;
      valid_r <= 1'b0;
      rise_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      prev_r <= a;
      if (load_s) begin
        valid_r <= 1'b1;
        rise_r  <= rise_s;
      end else if (drain) begin
        valid_r <= 1'b0;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign pend_valid = valid_r;
  assign pend_rise  = rise_r;
  assign overflow   = ovf_r;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event controller: per-channel detectors feeding a
// round-robin scheduler that presents one registered event at a time.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   a_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [CH_W-1:0]     evt_ch_o,
  output logic                evt_rise_o,
  output logic [NUM_CH-1:0]   overflow_o,
  input  logic                ovf_clr_i
);

  logic [NUM_CH-1:0] pend_valid_s;
  logic [NUM_CH-1:0] pend_rise_s;
  logic [NUM_CH-1:0] drain_s;

  arb_state_t        state_r;
  arb_state_t        state_nxt;
  logic              evt_valid_r;
  logic              valid_nxt;
  logic [CH_W-1:0]   evt_ch_r;
  logic [CH_W-1:0]   ch_nxt;
  logic              evt_rise_r;
  logic              rise_nxt;
  logic [CH_W-1:0]   last_grant_r;

  logic              grant_s;
  logic              sel_found_s;
  logic [CH_W-1:0]   sel_ch_s;
  logic [CH_W-1:0]   idx_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_chan u_chan (
      .clk        (clk),
      .reset      (reset),
      .a          (a_i[g]),
      .mode       (edge_mode_t'(mode_i[2*g+1:2*g])),
      .drain      (drain_s[g]),
      .ovf_clr    (ovf_clr_i),
      .pend_valid (pend_valid_s[g]),
      .pend_rise  (pend_rise_s[g]),
      .overflow   (overflow_o[g])
    );
  end

  // Round-robin pick: first valid slot after the last grant, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_ch_s    = '0;
    idx_s       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_s = CH_W'((int'(last_grant_r) + i) % NUM_CH);
      if (!sel_found_s && pend_valid_s[idx_s]) begin
        sel_found_s = 1'b1;
        sel_ch_s    = idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Scheduler next state and next event fields; a grant may chain straight off a handshake.
  always_comb begin
    state_nxt = state_r;
    valid_nxt = evt_valid_r;
    ch_nxt    = evt_ch_r;
    rise_nxt  = evt_rise_r;
    grant_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          grant_s = 1'b1;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      PRESENT: begin
        if (evt_ready_i) begin
          if (sel_found_s) begin
            grant_s = 1'b1;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    if (grant_s) begin
      state_nxt = PRESENT;
      valid_nxt = 1'b1;
      ch_nxt    = sel_ch_s;
      rise_nxt  = pend_rise_s[sel_ch_s];
    end else begin
      ch_nxt = ch_nxt;
    end
  end

  // Drain only the granted channel's slot.
  always_comb begin
    drain_s = '0;
    if (grant_s) begin
      drain_s[sel_ch_s] = 1'b1;
    end else begin
      drain_s = '0;
    end
  end

  // Scheduler state and registered event outputs; last_grant starts at the top channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      evt_valid_r  <= 1'b0;
      evt_ch_r     <= '0;
      evt_rise_r   <= 1'b0;
      last_grant_r <= CH_W'(NUM_CH - 1);
    end else begin
      state_r     <= state_nxt;
      evt_valid_r <= valid_nxt;
      evt_ch_r    <= ch_nxt;
      evt_rise_r  <= rise_nxt;
      if (grant_s) begin
        last_grant_r <= sel_ch_s;
      end
    end
  end

  assign evt_valid_o = evt_valid_r;
  assign evt_ch_o    = evt_ch_r;
  assign evt_rise_o  = evt_rise_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (NUM_CH=4).
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] a_i;
  logic [7:0] mode_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_ch_o;
  logic       evt_rise_o;
  logic [3:0] overflow_o;
  logic       ovf_clr_i;

  int checks = 0;
  int errors = 0;
  int n_evt;
  int n_rise;

  edge_event_arbiter #(.NUM_CH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .mode_i      (mode_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_ch_o    (evt_ch_o),
    .evt_rise_o  (evt_rise_o),
    .overflow_o  (overflow_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] ch, input logic r);
    chk({tag, "_valid"}, {31'd0, evt_valid_o}, {31'd0, v});
    if (v) begin
      chk({tag, "_ch"}, {30'd0, evt_ch_o}, {30'd0, ch});
      chk({tag, "_rise"}, {31'd0, evt_rise_o}, {31'd0, r});
    end
  endtask

  // Toggle ch0 eight times then drain, counting delivered events.
  task automatic toggle_count();
    n_evt  = 0;
    n_rise = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) a_i[0] = ~a_i[0];
      tick();
      if (evt_valid_o && evt_ch_o == 2'd0) begin
        n_evt++;
        if (evt_rise_o) n_rise++;
      end
    end
  endtask

  initial begin
    // 1: line held high through reset
    reset = 1'b0; a_i = 4'b0001; mode_i = 8'hFF; evt_ready_i = 1'b1; ovf_clr_i = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, evt_valid_o}, 32'd0);
    chk("rst_ch", {30'd0, evt_ch_o}, 32'd0);
    chk("rst_rise", {31'd0, evt_rise_o}, 32'd0);
    chk("rst_ovf", {28'd0, overflow_o}, 32'd0);
    reset = 1'b1;
    tick(); chk_evt("t1_p1", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("t1_p2", 1'b1, 2'd0, 1'b1);
    tick(); chk_evt("t1_p3", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("t1_p4", 1'b0, 2'd0, 1'b0);

    // 2: simultaneous edges from a fresh reset
    reset = 1'b0; mode_i = 8'h00; a_i = 4'b1000;
    tick();
    reset = 1'b1;
    tick(); tick();
    mode_i = 8'hFF; a_i = 4'b0101;
    tick(); chk_evt("t2_load", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("t2_e0", 1'b1, 2'd0, 1'b1);
    tick(); chk_evt("t2_e1", 1'b1, 2'd2, 1'b1);
    tick(); chk_evt("t2_e2", 1'b1, 2'd3, 1'b0);
    tick(); chk_evt("t2_end", 1'b0, 2'd0, 1'b0);

    // 3: overflow under backpressure
    evt_ready_i = 1'b0;
    a_i = 4'b0111; tick();
    a_i = 4'b0101; tick();
    chk_evt("t3_pres", 1'b1, 2'd1, 1'b1);
    chk("t3_ovf0", {28'd0, overflow_o}, 32'd0);
    a_i = 4'b0111; tick();
    chk_evt("t3_hold1", 1'b1, 2'd1, 1'b1);
    chk("t3_ovf1", {28'd0, overflow_o}, 32'h2);
    tick();
    chk_evt("t3_hold2", 1'b1, 2'd1, 1'b1);
    evt_ready_i = 1'b1;
    tick(); chk_evt("t3_fall", 1'b1, 2'd1, 1'b0);
    tick(); chk_evt("t3_end", 1'b0, 2'd0, 1'b0);
    chk("t3_ovf_sticky", {28'd0, overflow_o}, 32'h2);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("t3_ovf_clr", {28'd0, overflow_o}, 32'd0);
    chk_evt("t3_idle", 1'b0, 2'd0, 1'b0);

    // 4: mode filtering on ch0 (ch0 starts high)
    mode_i = 8'h01; tick();
    toggle_count();
    chk("t4_rise_evts", n_evt, 32'd4);
    chk("t4_rise_type", n_rise, 32'd4);
    mode_i = 8'h00;
    toggle_count();
    chk("t4_off_evts", n_evt, 32'd0);
    mode_i = 8'h02;
    toggle_count();
    chk("t4_fall_evts", n_evt, 32'd4);
    chk("t4_fall_type", n_rise, 32'd0);

    // 5: round-robin after a grant to ch2 (a_i is 0111 here)
    mode_i = 8'hFF; evt_ready_i = 1'b0;
    a_i = 4'b0011; tick();
    a_i = 4'b1010; tick();
    chk_evt("t5_g2", 1'b1, 2'd2, 1'b0);
    evt_ready_i = 1'b1;
    tick(); chk_evt("t5_g3", 1'b1, 2'd3, 1'b1);
    tick(); chk_evt("t5_g0", 1'b1, 2'd0, 1'b0);
    tick(); chk_evt("t5_end", 1'b0, 2'd0, 1'b0);

    // 6: async reset mid-handshake with overflow set
    evt_ready_i = 1'b0;
    a_i = 4'b1000; tick();
    a_i = 4'b1010; tick();
    a_i = 4'b1000; tick();
    chk_evt("t6_pres", 1'b1, 2'd1, 1'b0);
    chk("t6_ovf", {28'd0, overflow_o}, 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, evt_valid_o}, 32'd0);
    chk("t6_async_ovf", {28'd0, overflow_o}, 32'd0);
    a_i = 4'b0000;
    tick();
    reset = 1'b1; evt_ready_i = 1'b1;
    tick(); chk_evt("t6_after1", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("t6_after2", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("t6_after3", 1'b0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller built around the single-bit edge detector datapath. It samples NUM_CH synchronous input lines, detects rising and falling edges per channel under a per-channel mode, and buffers one pending edge per channel. A round-robin scheduler serialises the pending edges onto a single valid/ready event port, one event per cycle. The block sits between raw status lines and a single event consumer, such as an interrupt aggregator or logger.

## Interface
- NUM_CH, default 4: number of input channels; legal range is 2..16.
- CH_W, default $clog2(NUM_CH): channel-index width. It is derived and must not be overridden.
- One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- a_i  in  NUM_CH  raw channel lines, synchronous to clk.
- mode_i  in  2*NUM_CH  per-channel mode; channel n uses bits [2n+1:2n]. Encoding: 00 off, 01 rise, 10 fall, 11 both.
- evt_valid_o  out  1  event present on the output.
- evt_ready_i  in  1  consumer accepts the event.
- evt_ch_o  out  CH_W  channel index of the presented event.
- evt_rise_o  out  1  edge type: 1 is rising, 0 is falling.
- overflow_o  out  NUM_CH  sticky per-channel flag: an edge was dropped.
- ovf_clr_i  in  1  clears all overflow flags.

## Operation
- **Per-channel detection.** Each channel has a prev register holding the last sample of a_i[n].
  - rise = a & ~prev; fall = ~a & prev.
  - Each is masked by mode_i in the same cycle.
  - A mode change affects detection starting in the cycle it is applied. It never clears an already-pending edge.
- **Pending slot.** Each channel has a one-entry slot holding a valid bit and an edge type.
  - A qualified edge loads the slot.
  - If the slot is occupied and is not being drained in the same cycle, the new edge is dropped, the oldest edge is kept, and overflow_o[n] is set.
  - If the slot drains and a new edge arrives in the same cycle, the new edge loads the slot.
- **Scheduler FSM.**
  - IDLE: if any slot is valid, grant the first valid channel searching from last_grant+1 with wrap-around. Load evt_ch_o and evt_rise_o, clear that slot, set evt_valid_o, and go to PRESENT.
  - PRESENT: hold all outputs until evt_valid_o && evt_ready_i.
  - On that handshake, if any slot is valid, grant the next channel in the same cycle, so there is no bubble. Otherwise clear evt_valid_o and go to IDLE.
  - last_grant updates on every grant.
- **Overflow flags.** A flag sets on a drop and clears on ovf_clr_i. If a drop and a clear happen on the same channel in the same cycle, the set wins.
- **Impossible case.** A rise and a fall on the same channel in the same cycle cannot occur and needs no handling.

## Timing
- **Reset values.**
  - Outputs: evt_valid_o=0, evt_ch_o=0, evt_rise_o=0, overflow_o=0.
  - Internal state: all prev=0, all slots empty, FSM=IDLE, last_grant=NUM_CH-1, so channel 0 has first priority.
- **Reset mid-operation.** Asserting reset forces evt_valid_o low immediately, without waiting for a clock. Any presented or pending events are lost.
- **Latency.**
  - An a_i change before posedge k is captured in the slot at posedge k.
  - evt_valid_o is high after posedge k+1, with an empty pipe.
- **Throughput.** One event per cycle while evt_ready_i is held high.
- **Handshake.**
  - evt_valid_o, evt_ch_o and evt_rise_o are registered.
  - evt_valid_o has no combinational path from evt_ready_i.
  - Once evt_valid_o is asserted, it stays asserted and all event fields stay stable until the handshake completes.
- **Post-reset edges.** Because prev resets to 0, a line held high through reset release produces one rising edge on the first clock after release, if the mode permits it.

## Structure
- **Package edge_evt_pkg** holds:
  - the edge_mode_t enum: OFF, RISE, FALL, BOTH;
  - the arb_state_t enum: IDLE, PRESENT;
  - the edge_evt_t struct: ch, rise.
- **Sub-module edge_chan**, instantiated NUM_CH times. It contains the prev register, mode masking, the pending slot and the overflow flag. It has a drain input and outputs pend_valid and pend_rise.
- **Top level** holds the round-robin selection, the FSM and the output registers.

## Test plan
1. **Reset with line held high.** NUM_CH=4, mode all 11, a_i=4'b0001 held through reset, evt_ready_i=1. After release, evt_valid_o rises after the 2nd posedge with ch=0, rise=1. Exactly one event is produced, then IDLE.
2. **Simultaneous edges.** In one cycle, ch0 and ch2 rise and ch3 falls, with evt_ready_i=1. Events appear on consecutive cycles, in order (0,1), (2,1), (3,0), with no bubbles.
3. **Overflow under backpressure.** evt_ready_i=0 while ch1 goes 0→1→0→1 on consecutive cycles.
   - The output holds (1,1) stably.
   - The slot holds the fall.
   - The third edge is dropped and overflow_o=4'b0010.
   - After evt_ready_i=1, only (1,1) and (1,0) are delivered. ovf_clr_i then clears the flag.
4. **Mode filtering.** With ch0 mode=01, 8 edges on ch0 yield exactly 4 rising events. With mode=00 they yield none. With mode=10 they yield 4 falling events.
5. **Round-robin order.** After a grant to ch2, slots for ch0 and ch3 become valid in the same cycle. ch3 is granted before ch0.
6. **Async reset mid-handshake.** Assert reset while evt_valid_o=1 and evt_ready_i=0, with overflow_o nonzero. evt_valid_o and overflow_o go to 0 before the next posedge. After release, no stale event is presented.
